fe_sdf_feedback: RTL
====================

FE_SDF_FEEDBACK -- requirements
Module: fe_sdf_feedback

Interface
REQ-001 SHALL have parameter NBW_IN, default 'd8, meaning signed bit width of input I/Q samples.
REQ-002 SHALL have parameter NBW_OUT, default NBW_IN+1, meaning signed bit width of butterfly results, delay-line words and o_data.
REQ-003 SHALL have parameter NBW_L, default 'd2, meaning log2 of delay length L (L = 2**NBW_L complex samples); NBW_L >= 1.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_async_n, input, 1, meaning the reset, which is asynchronous and active-low.
REQ-006 SHALL have port i_valid, input, 1, meaning i_data holds a valid serial complex sample this cycle.
REQ-007 SHALL have port i_data[1:0], input, signed NBW_IN each, meaning serial sample, index 0 = I, 1 = Q.
REQ-008 SHALL have port o_bf_valid, output, 1, meaning butterfly operands valid; drives the butterfly i_valid.
REQ-009 SHALL have port o_bf_data[1:0][1:0], output, signed NBW_IN each, meaning butterfly operands [leg][I/Q]: leg 0 = delayed sample, leg 1 = current sample.
REQ-010 SHALL have port i_bf_data[1:0][1:0], input, signed NBW_OUT each, meaning butterfly results [leg][I/Q] for the operands in the same cycle (combinational butterfly).
REQ-011 SHALL have port o_valid, output, 1, meaning o_data valid.
REQ-012 SHALL have port o_data[1:0], output, signed NBW_OUT each, meaning serial stage output, I/Q.

Function
REQ-013 SHALL keep a phase counter cnt of NBW_L+1 bits, incremented by 1 only on cycles with i_valid=1 and wrapping 2L-1 -> 0; phase = cnt[NBW_L].
REQ-014 SHALL keep a delay line of L complex words, NBW_OUT bits per component, advancing one position only when i_valid=1; tail = oldest word.
REQ-015 SHALL, in fill phase (phase=0) with i_valid=1, shift in i_data sign-extended to NBW_OUT and present tail on the output path.
REQ-016 SHALL, in compute phase (phase=1), drive o_bf_data[0] = tail truncated to NBW_IN bits (lossless, the word was sign-extended input), o_bf_data[1] = i_data, o_bf_valid = i_valid.
REQ-017 SHALL drive o_bf_valid=0 in fill phase; o_bf_data SHALL then still equal tail/i_data (don't-care for consumers).
REQ-018 SHALL, in compute phase with i_valid=1, shift i_bf_data[1] into the delay line and present i_bf_data[0] on the output path.
REQ-019 SHALL register the output path: o_data and o_valid update one clk after the qualifying i_valid cycle (latency 1 cycle from accepted sample).
REQ-020 SHALL keep flag primed, set when cnt wraps 2L-1 -> 0 and never cleared except by reset.
REQ-021 SHALL assert o_valid for compute-phase samples always, and for fill-phase samples only when primed=1 (first fill output is discarded).
REQ-022 SHALL hold o_data and deassert o_valid on cycles following i_valid=0; gaps SHALL not alter cnt, delay line or primed.
REQ-023 SHALL perform no arithmetic other than sign extension; overflow handling belongs to the butterfly.

Reset
REQ-024 SHALL, on rst_async_n=0, immediately clear cnt, primed, all delay-line words, o_data (all 0) and o_valid (0); o_bf_valid SHALL read 0 while in reset.
REQ-025 SHALL, on reset asserted mid-block, discard the partial block; after release the first accepted sample is block sample 0 of a fill phase with primed=0.

Verification (L=4, ideal butterfly model [0]=a+b, [1]=a-b)
REQ-026 SHALL cover: continuous i_valid, I=1..8, Q=0 -> o_bf_valid on samples 5-8 with pairs (1,5),(2,6),(3,7),(4,8); o_data.I = 6,8,10,12 one cycle later; no o_valid during samples 1-4.
REQ-027 SHALL cover: continue with I=9..12 -> o_data.I = -4,-4,-4,-4 (stored differences), o_valid=1.
REQ-028 SHALL cover: same stream with i_valid=0 every other cycle -> identical o_data sequence, o_valid only after valid samples, cnt frozen in gaps.
REQ-029 SHALL cover: full-scale I=-128, Q=127 in both legs -> o_bf_data exact, delay tail sign-extended to -128/127, no truncation error.
REQ-030 SHALL cover: reset asserted after sample 6 -> all outputs 0 immediately; restart with I=1..8 reproduces REQ-026 exactly.
REQ-031 SHALL cover: cnt wrap over 3 consecutive blocks -> primed set once, o_bf_valid pattern 4 low / 4 high repeating.

Source files
------------

// File: rtl/fe_sdf_feedback.sv
// Single-path delay feedback (SDF) FFT stage front end: delay line, phase control
// and output mux around an external combinational radix-2 butterfly.
//
// Ports:
//   clk, rst_async_n        : clock, asynchronous active-low reset
//   i_valid, i_data[I/Q]    : serial complex input samples (NBW_IN signed)
//   o_bf_valid, o_bf_data   : butterfly operands [leg][I/Q], leg 0 = delayed,
//                             leg 1 = current sample (NBW_IN signed)
//   i_bf_data               : butterfly results [leg][I/Q] (NBW_OUT signed)
//   o_valid, o_data[I/Q]    : registered serial stage output (NBW_OUT signed)

module fe_sdf_feedback #(
    parameter int NBW_IN  = 'd8,
    parameter int NBW_OUT = NBW_IN + 1,
    parameter int NBW_L   = 'd2
) (
    input  logic                      clk,
    input  logic                      rst_async_n,
    input  logic                      i_valid,
    input  logic signed [NBW_IN-1:0]  i_data    [1:0],
    output logic                      o_bf_valid,
    output logic signed [NBW_IN-1:0]  o_bf_data [1:0][1:0],
    input  logic signed [NBW_OUT-1:0] i_bf_data [1:0][1:0],
    output logic                      o_valid,
    output logic signed [NBW_OUT-1:0] o_data    [1:0]
);

    localparam int L = 2 ** NBW_L;
    localparam logic [NBW_L:0] CNT_LAST = (NBW_L + 1)'(2 * L - 1);
    localparam logic [NBW_L:0] CNT_ONE  = (NBW_L + 1)'(1);

    // Block sample counter; the MSB selects fill (0) or compute (1) phase.
    logic [NBW_L:0] cnt;
    logic           phase;
    logic           primed;
    logic           wrap;

    // line[L-1] is the oldest word (tail), line[0] the newest.
    logic signed [NBW_OUT-1:0] line     [L][2];
    logic signed [NBW_OUT-1:0] shift_in [2];
    logic signed [NBW_OUT-1:0] path     [2];

    assign phase = cnt[NBW_L];
    assign wrap  = i_valid && (cnt == CNT_LAST);

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            shift_in[c] = NBW_OUT'(i_data[c]);
            path[c]     = line[L-1][c];
            if (phase) begin
                // Difference leg is recirculated, sum leg goes out now.
                shift_in[c] = i_bf_data[1][c];
                path[c]     = i_bf_data[0][c];
            end
        end
    end

    // The tail is a sign-extended input word whenever phase=1, so the
    // truncation back to NBW_IN bits loses nothing where it matters.
    always_comb begin
        o_bf_valid = phase && i_valid;
        for (int c = 0; c < 2; c++) begin
            o_bf_data[0][c] = NBW_IN'(line[L-1][c]);
            o_bf_data[1][c] = i_data[c];
        end
    end

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            cnt     <= '0;
            primed  <= 1'b0;
            o_valid <= 1'b0;
            for (int c = 0; c < 2; c++) begin
                o_data[c] <= '0;
            end
            for (int k = 0; k < L; k++) begin
                line[k][0] <= '0;
                line[k][1] <= '0;
            end
        end else begin
            // The first fill block after reset outputs stale zeros: suppress.
            o_valid <= i_valid && (phase || primed);
            if (i_valid) begin
                cnt <= wrap ? '0 : cnt + CNT_ONE;
                if (wrap) begin
                    primed <= 1'b1;
                end
                for (int k = L - 1; k > 0; k--) begin
                    line[k] <= line[k-1];
                end
                for (int c = 0; c < 2; c++) begin
                    line[0][c] <= shift_in[c];
                    o_data[c]  <= path[c];
                end
            end
        end
    end

endmodule
